// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: instruction fields, ALU flags and control strobes of the multi-cycle controller
interface multi_cycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] State;
    logic [3:0] Flags;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
        input  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Flags
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA,
        output ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, State, Flags
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle ARM-subset control FSM with conditional execution and flag register
module multi_cycle_ctrl (
    input logic               CLK,
    input logic               Reset,
    multi_cycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic       cond_now, cond_ex;
    logic       next_pc, reg_w, mem_w, branch, alu_op;
    logic       ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_ctrl;
    logic [3:0] cmd;
    logic       n, z, c, v;

    assign cmd = bus.Funct[4:1];
    assign {n, z, c, v} = flags_q;

    // Condition check against the registered flags
    always_comb begin
        cond_now = 1'b0;
        case (bus.Cond)
            4'b0000: cond_now = z;
            4'b0001: cond_now = !z;
            4'b0010: cond_now = c;
            4'b0011: cond_now = !c;
            4'b0100: cond_now = n;
            4'b0101: cond_now = !n;
            4'b0110: cond_now = v;
            4'b0111: cond_now = !v;
            4'b1000: cond_now = c && !z;
            4'b1001: cond_now = !c || z;
            4'b1010: cond_now = n == v;
            4'b1011: cond_now = n != v;
            4'b1100: cond_now = !z && (n == v);
            4'b1101: cond_now = z || (n != v);
            4'b1110: cond_now = 1'b1;
            default: cond_now = 1'b0;
        endcase
    end

    // Freeze the condition in DECODE so a flag update in EXEC cannot change this instruction's ALUWB strobes
    always_comb begin
        cond_d  = (state_q == DECODE) ? cond_now : cond_q;
        cond_ex = (state_q == FETCH || state_q == DECODE) ? cond_now : cond_q;
    end

    // Next-state logic
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = (bus.Op == 2'b01) ? MEMADR :
                              (bus.Op == 2'b00) ? (bus.Funct[5] ? EXECI : EXECR) :
                              (bus.Op == 2'b10) ? BRANCH : FETCH;
            MEMADR: state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Raw per-state controls
    always_comb begin
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR:  alu_op = 1'b1;
            EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ALUWB:  reg_w = cmd != 4'b1010;
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decode
    always_comb begin
        alu_ctrl = !alu_op ? 2'b00 :
                   (cmd == 4'b0100) ? 2'b00 :
                   (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01 :
                   (cmd == 4'b0000) ? 2'b10 :
                   (cmd == 4'b1100) ? 2'b11 : 2'b00;
    end

    // Flag update at the end of EXEC; C/V only follow arithmetic commands
    always_comb begin
        flags_d = flags_q;
        if ((state_q == EXECR || state_q == EXECI) && cond_ex && bus.Funct[0]) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
                flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    // State, flag and latched-condition registers
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    assign bus.PCWrite    = next_pc || (((reg_w && bus.Rd == 4'hF) || branch) && cond_ex);
    assign bus.RegWrite   = reg_w && cond_ex;
    assign bus.MemWrite   = mem_w && cond_ex;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_ctrl;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.State      = state_q;
    assign bus.Flags      = flags_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed instruction sequences with hand-computed control and flag expectations
module tb_multi_cycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    multi_cycle_ctrl_if bus();

    multi_cycle_ctrl dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] alu_flags);
        bus.Cond     = cond;
        bus.Op       = op;
        bus.Funct    = funct;
        bus.Rd       = rd;
        bus.ALUFlags = alu_flags;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 8'(bus.State), 8'd0);
        chk("rst_flags", 8'(bus.Flags), 8'h0);
        chk("rst_regw", 8'(bus.RegWrite), 8'd0);
        chk("rst_memw", 8'(bus.MemWrite), 8'd0);
        chk("fetch_irw", 8'(bus.IRWrite), 8'd1);
        chk("fetch_pcw", 8'(bus.PCWrite), 8'd1);
        chk("fetch_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("fetch_srcb", 8'(bus.ALUSrcB), 8'd2);
        chk("fetch_res", 8'(bus.ResultSrc), 8'd2);
        // LDR AL
        set(4'b1110, 2'b01, 6'b011001, 4'd1, 4'b0000);
        rst_n = 1'b1;
        tick;
        chk("ldr_s1", 8'(bus.State), 8'd1);
        chk("ldr_imm", 8'(bus.ImmSrc), 8'd1);
        chk("ldr_regsrc", 8'(bus.RegSrc), 8'd2);
        tick;
        chk("ldr_s2", 8'(bus.State), 8'd2);
        chk("ldr_srcb", 8'(bus.ALUSrcB), 8'd1);
        tick;
        chk("ldr_s3", 8'(bus.State), 8'd3);
        chk("ldr_adr", 8'(bus.AdrSrc), 8'd1);
        chk("ldr_rd_regw", 8'(bus.RegWrite), 8'd0);
        tick;
        chk("ldr_s4", 8'(bus.State), 8'd4);
        chk("ldr_wb_regw", 8'(bus.RegWrite), 8'd1);
        chk("ldr_wb_res", 8'(bus.ResultSrc), 8'd1);
        tick;
        chk("ldr_s0", 8'(bus.State), 8'd0);
        // STR EQ with Z=0: suppressed
        set(4'b0000, 2'b01, 6'b011000, 4'd1, 4'b0000);
        tick;
        tick;
        chk("str1_s2", 8'(bus.State), 8'd2);
        tick;
        chk("str1_s5", 8'(bus.State), 8'd5);
        chk("str1_memw", 8'(bus.MemWrite), 8'd0);
        chk("str1_adr", 8'(bus.AdrSrc), 8'd1);
        tick;
        chk("str1_s0", 8'(bus.State), 8'd0);
        // SUBS reg sets Z
        set(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100);
        tick;
        tick;
        chk("subs_s6", 8'(bus.State), 8'd6);
        chk("subs_aluc", 8'(bus.ALUControl), 8'd1);
        chk("subs_srcb", 8'(bus.ALUSrcB), 8'd0);
        tick;
        chk("subs_s8", 8'(bus.State), 8'd8);
        chk("subs_flags", 8'(bus.Flags), 8'h4);
        chk("subs_regw", 8'(bus.RegWrite), 8'd1);
        chk("subs_aluc_wb", 8'(bus.ALUControl), 8'd0);
        tick;
        // STR EQ with Z=1: performed
        set(4'b0000, 2'b01, 6'b011000, 4'd1, 4'b0000);
        tick;
        tick;
        tick;
        chk("str2_s5", 8'(bus.State), 8'd5);
        chk("str2_memw", 8'(bus.MemWrite), 8'd1);
        tick;
        // ADDS imm
        set(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
        tick;
        tick;
        chk("adds_s7", 8'(bus.State), 8'd7);
        chk("adds_aluc", 8'(bus.ALUControl), 8'd0);
        chk("adds_srcb", 8'(bus.ALUSrcB), 8'd1);
        tick;
        chk("adds_flags", 8'(bus.Flags), 8'h6);
        tick;
        // ANDS reg: C,V held
        set(4'b1110, 2'b00, 6'b000001, 4'd1, 4'b1000);
        tick;
        tick;
        chk("ands_aluc", 8'(bus.ALUControl), 8'd2);
        tick;
        chk("ands_flags", 8'(bus.Flags), 8'hA);
        tick;
        // ORR reg, no S: flags untouched
        set(4'b1110, 2'b00, 6'b011000, 4'd1, 4'b0101);
        tick;
        tick;
        chk("orr_aluc", 8'(bus.ALUControl), 8'd3);
        tick;
        chk("orr_flags", 8'(bus.Flags), 8'hA);
        tick;
        // CMP
        set(4'b1110, 2'b00, 6'b010101, 4'd1, 4'b0100);
        tick;
        tick;
        chk("cmp_aluc", 8'(bus.ALUControl), 8'd1);
        tick;
        chk("cmp_s8", 8'(bus.State), 8'd8);
        chk("cmp_regw", 8'(bus.RegWrite), 8'd0);
        chk("cmp_flags", 8'(bus.Flags), 8'h4);
        tick;
        // ADDS EQ clears Z on its own EXEC edge; its ALUWB write must still happen
        set(4'b0000, 2'b00, 6'b001001, 4'd2, 4'b0000);
        tick;
        tick;
        tick;
        chk("addeq_flags", 8'(bus.Flags), 8'h0);
        chk("addeq_regw", 8'(bus.RegWrite), 8'd1);
        chk("addeq_pcw", 8'(bus.PCWrite), 8'd0);
        tick;
        // SUBS EQ with Z=0: sequence unchanged, strobes and flags suppressed
        set(4'b0000, 2'b00, 6'b000101, 4'd2, 4'b0100);
        tick;
        tick;
        chk("subne_s6", 8'(bus.State), 8'd6);
        tick;
        chk("subne_s8", 8'(bus.State), 8'd8);
        chk("subne_regw", 8'(bus.RegWrite), 8'd0);
        chk("subne_flags", 8'(bus.Flags), 8'h0);
        tick;
        chk("subne_s0", 8'(bus.State), 8'd0);
        // ADD to PC (Rd=15)
        set(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b1111);
        tick;
        tick;
        tick;
        chk("addpc_pcw", 8'(bus.PCWrite), 8'd1);
        chk("addpc_regw", 8'(bus.RegWrite), 8'd1);
        chk("addpc_flags", 8'(bus.Flags), 8'h0);
        tick;
        // B AL
        set(4'b1110, 2'b10, 6'b000000, 4'd0, 4'b0000);
        tick;
        chk("bal_s1", 8'(bus.State), 8'd1);
        tick;
        chk("bal_s9", 8'(bus.State), 8'd9);
        chk("bal_pcw", 8'(bus.PCWrite), 8'd1);
        chk("bal_imm", 8'(bus.ImmSrc), 8'd2);
        chk("bal_regsrc", 8'(bus.RegSrc), 8'd1);
        chk("bal_res", 8'(bus.ResultSrc), 8'd2);
        tick;
        chk("bal_s0", 8'(bus.State), 8'd0);
        // B NV
        set(4'b1111, 2'b10, 6'b000000, 4'd0, 4'b0000);
        tick;
        tick;
        chk("bnv_s9", 8'(bus.State), 8'd9);
        chk("bnv_pcw", 8'(bus.PCWrite), 8'd0);
        tick;
        // Undefined Op
        set(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        tick;
        chk("und_s1", 8'(bus.State), 8'd1);
        tick;
        chk("und_s0", 8'(bus.State), 8'd0);
        // ADDS sets all flags
        set(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1111);
        tick;
        tick;
        tick;
        chk("addf_flags", 8'(bus.Flags), 8'hF);
        tick;
        // Reset during MEMRD
        set(4'b1110, 2'b01, 6'b011001, 4'd1, 4'b0000);
        tick;
        tick;
        tick;
        chk("mr_s3", 8'(bus.State), 8'd3);
        rst_n = 1'b0;
        tick;
        chk("mr_state", 8'(bus.State), 8'd0);
        chk("mr_flags", 8'(bus.Flags), 8'h0);
        chk("mr_regw", 8'(bus.RegWrite), 8'd0);
        chk("mr_memw", 8'(bus.MemWrite), 8'd0);
        rst_n = 1'b1;
        chk("mr_irw", 8'(bus.IRWrite), 8'd1);
        tick;
        chk("mr_s1", 8'(bus.State), 8'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL provide `CLK  input  1`: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL provide `Reset  input  1`: synchronous, active-low reset, sampled on the rising CLK edge.
REQ-003 The block SHALL provide `Cond  input  4`: Instr[31:28], the condition field.
REQ-004 The block SHALL provide `Op  input  2`: Instr[27:26] (00 data-processing, 01 memory, 10 branch, 11 undefined).
REQ-005 The block SHALL provide `Funct  input  6`: Instr[25:20] (bit5 = I, bits4:1 = cmd, bit0 = S for DP or L for memory).
REQ-006 The block SHALL provide `Rd  input  4`: Instr[15:12].
REQ-007 The block SHALL provide `ALUFlags  input  4`: {N,Z,C,V} from the ALU in the current cycle.
REQ-008 The block SHALL provide the single-bit outputs `PCWrite`, `RegWrite`, `MemWrite`, `IRWrite` and `AdrSrc` (the final, condition-gated strobes).
REQ-009 The block SHALL provide the 2-bit outputs `ResultSrc`, `ALUSrcB`, `ImmSrc`, `RegSrc` and `ALUControl`, plus the 1-bit output `ALUSrcA`.
REQ-010 The block SHALL provide `State  output  4`: the current FSM state, for debug and verification.
REQ-011 The block SHALL provide `Flags  output  4`: the registered {N,Z,C,V}.

Function
REQ-012 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
  - Codes 10-15 SHALL return to FETCH on the next edge.
REQ-013 The FSM SHALL make these transitions:
  - FETCH->DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB.
  - MEMWB, MEMWR, BRANCH and ALUWB -> FETCH.
  - EXECR and EXECI -> ALUWB.
REQ-014 Latency SHALL be: branch 3 cycles, store 4, data-processing 4, load 5, undefined-Op 2.
REQ-015 All outputs SHALL be combinational functions of State, the instruction fields and Flags, with these per-state raw controls (any field not listed = 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1 unless cmd=1010 (CMP).
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-016 ALUControl SHALL be 00 when ALUOp=0. When ALUOp=1 it SHALL decode cmd as: 0100 ADD->00, 0010 SUB->01, 1010 CMP->01, 0000 AND->10, 1100 ORR->11; any other cmd ->00.
REQ-017 ImmSrc SHALL equal Op in every state. RegSrc[0] SHALL be (Op==10) and RegSrc[1] SHALL be (Op==01).
REQ-018 CondEx SHALL be evaluated from Cond and the registered Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL(1110)=1, 1111=0.
REQ-019 PCS SHALL be (RegW & Rd==15) | Branch.
REQ-020 The gated strobes SHALL be:
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
REQ-021 Flags SHALL update only on the edge that ends EXECR or EXECI, and only when CondEx=1 and Funct[0]=1.
  - N and Z SHALL load from ALUFlags.
  - C and V SHALL load only if cmd is ADD, SUB or CMP; otherwise they SHALL hold.
REQ-022 CondEx SHALL use Flags as they stood before any update made by the same instruction. A flag update on the EXEC edge SHALL NOT alter that instruction's own ALUWB strobes.
REQ-023 A failed condition SHALL NOT alter the state sequence; only the gated strobes and the flag update are suppressed.

Reset
REQ-024 While Reset=0 at a rising edge, State SHALL become FETCH and Flags SHALL become 0000 on that edge.
REQ-025 Reset SHALL take priority over every transition, including mid-instruction; no RegWrite or MemWrite SHALL be asserted in the cycle that follows reset.
REQ-026 After reset release, the first cycle SHALL be FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-027 LDR, AL (Op=01, Funct=011001) SHALL step State 0,1,2,3,4,0 with RegWrite=1 only in MEMWB and ResultSrc=01 there.
REQ-028 STR with Cond=0000 and Z=0 SHALL step State 0,1,2,5,0 with MemWrite=0 throughout; after setting Z=1 via SUBS, the same STR SHALL assert MemWrite=1 in MEMWR.
REQ-029 ADDS imm (Funct=101001) with ALUFlags=0110 in EXECI SHALL give Flags=0110 after the edge; a following ANDS with ALUFlags=1000 SHALL give Flags=1010 (C,V held).
REQ-030 CMP (cmd=1010, S=1) SHALL produce ALUControl=01 in EXECR and RegWrite=0 in ALUWB.
REQ-031 Branch with Cond=1110 SHALL step 0,1,9,0 with PCWrite=1 in BRANCH and ImmSrc=10; the same branch with Cond=1111 SHALL give PCWrite=0 in BRANCH.
REQ-032 Reset=0 asserted while in MEMRD SHALL put State to 0 and Flags to 0000 on the next edge, with RegWrite=0.
